// File: rtl/dds_sweep_if.sv
// Control/data bundle between a sweep requester and dds_sweep_ctrl, plus the
// frequency/amplitude/divisor drive toward the triangle DDS.
interface dds_sweep_if #(
    parameter int PH_W    = 32,
    parameter int DT_W    = 8,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic [PH_W-1:0]    f_start;
    logic [PH_W-1:0]    f_stop;
    logic [PH_W-1:0]    f_step;
    logic [DWELL_W-1:0] dwell;
    logic [DT_W-1:0]    amp_in;
    logic [31:0]        sad_in;

    logic [PH_W-1:0]    freq_word;
    logic [DT_W-1:0]    amplitude;
    logic [31:0]        sad_freq;
    logic               dds_sync;
    logic               step_stb;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, f_start, f_stop, f_step, dwell, amp_in, sad_in,
        input  freq_word, amplitude, sad_freq, dds_sync, step_stb, busy, done
    );

    modport slave (
        input  start, abort, f_start, f_stop, f_step, dwell, amp_in, sad_in,
        output freq_word, amplitude, sad_freq, dds_sync, step_stb, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency sweep controller for a triangle DDS: f_start..f_stop in f_step
// increments, dwell cycles per point. SWEEP_BIDIR_EN adds the descending leg.
module dds_sweep_ctrl #(
    parameter int PH_W    = 32,
    parameter int DT_W    = 8,
    parameter int DWELL_W = 16
) (
    input logic       clk,
    input logic       rst,
    dds_sweep_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] dwell_q;
    logic [PH_W-1:0]    f_stop_q;
    logic [PH_W-1:0]    f_step_q;
    logic               last_q;
    logic [PH_W-1:0]    freq_q;
    logic [DT_W-1:0]    amp_q;
    logic [31:0]        sad_q;
    logic               sync_q;
    logic               stb_q;

    logic [DWELL_W-1:0] reload;
    logic [DWELL_W-1:0] start_reload;
    logic [PH_W:0]      up_sum;
    logic               up_top;

    // A dwell of 0 behaves as 1, so the counter reload never underflows.
    assign reload       = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
    assign start_reload = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
    assign up_sum       = {1'b0, freq_q} + {1'b0, f_step_q};
    assign up_top       = up_sum[PH_W] || (up_sum >= {1'b0, f_stop_q});

`ifdef SWEEP_BIDIR_EN
    logic [PH_W-1:0] f_start_q;
    logic            desc_q;
    logic [PH_W:0]   dn_diff;
    logic            dn_bot;

    assign dn_diff = {1'b0, freq_q} - {1'b0, f_step_q};
    assign dn_bot  = dn_diff[PH_W] || (dn_diff[PH_W-1:0] <= f_start_q);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dwell_q  <= '0;
            f_stop_q <= '0;
            f_step_q <= '0;
            last_q   <= 1'b0;
            freq_q   <= '0;
            amp_q    <= '0;
            sad_q    <= '0;
            sync_q   <= 1'b0;
            stb_q    <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            f_start_q <= '0;
            desc_q    <= 1'b0;
`endif
        end else begin
            sync_q <= 1'b0;
            stb_q  <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                state  <= S_IDLE;
                cnt    <= '0;
                freq_q <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            dwell_q  <= bus.dwell;
                            f_stop_q <= bus.f_stop;
                            f_step_q <= bus.f_step;
                            freq_q   <= bus.f_start;
                            amp_q    <= bus.amp_in;
                            sad_q    <= bus.sad_in;
                            sync_q   <= 1'b1;
                            stb_q    <= 1'b1;
                            cnt      <= start_reload;
                            state    <= S_DWELL;
                            // Degenerate sweeps collapse to the single point f_start.
                            last_q   <= (bus.f_step == '0) || (bus.f_start >= bus.f_stop);
`ifdef SWEEP_BIDIR_EN
                            f_start_q <= bus.f_start;
                            desc_q    <= 1'b0;
`endif
                        end
                    end
                    S_DWELL: begin
                        if (cnt == '0) state <= last_q ? S_FIN : S_STEP;
                        else           cnt   <= cnt - 1'b1;
                    end
                    S_STEP: begin
                        stb_q <= 1'b1;
                        cnt   <= reload;
                        state <= S_DWELL;
`ifdef SWEEP_BIDIR_EN
                        // Reaching the top turns the sweep around instead of ending it.
                        if (desc_q) begin
                            if (dn_bot) begin
                                freq_q <= f_start_q;
                                last_q <= 1'b1;
                            end else begin
                                freq_q <= dn_diff[PH_W-1:0];
                            end
                        end else if (up_top) begin
                            freq_q <= f_stop_q;
                            desc_q <= 1'b1;
                        end else begin
                            freq_q <= up_sum[PH_W-1:0];
                        end
`else
                        if (up_top) begin
                            freq_q <= f_stop_q;
                            last_q <= 1'b1;
                        end else begin
                            freq_q <= up_sum[PH_W-1:0];
                        end
`endif
                    end
                    S_FIN:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.freq_word = freq_q;
    assign bus.amplitude = amp_q;
    assign bus.sad_freq  = sad_q;
    assign bus.dds_sync  = sync_q;
    assign bus.step_stb  = stb_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_FIN);
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl; expected sequences follow SWEEP_BIDIR_EN.
module tb_dds_sweep_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [31:0] pts[$];
    int          stb_t[$];
    int          done_t, done_cnt, sync_cnt;
    logic        end_busy;

    always #5 clk = ~clk;

    dds_sweep_if #(.PH_W(32), .DT_W(8), .DWELL_W(16)) bus ();
    dds_sweep_ctrl #(.PH_W(32), .DT_W(8), .DWELL_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Launch a sweep and record every step_stb point/time and the done pulse.
    task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe,
                             input logic [31:0] st, input logic [15:0] dw);
        pts.delete(); stb_t.delete();
        done_t = -1; done_cnt = 0; sync_cnt = 0; end_busy = 1'b1;
        @(negedge clk);
        bus.f_start = fs; bus.f_stop = fe; bus.f_step = st; bus.dwell = dw;
        bus.amp_in = 8'h5A; bus.sad_in = 32'h1234_5678; bus.start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.step_stb) begin pts.push_back(bus.freq_word); stb_t.push_back(c); end
            if (bus.dds_sync) sync_cnt++;
            if (bus.done) begin done_cnt++; if (done_t < 0) done_t = c; end
            if (done_t >= 0 && c > done_t) begin end_busy = bus.busy; break; end
        end
    endtask

    task automatic check_sweep(input string nm, input logic [31:0] exp[$], input int dw_eff);
        n_chk++;
        if (done_t < 0) begin
            n_fail++; $display("FAIL %s timeout: no done within budget", nm);
        end
        n_chk++;
        if (pts.size() !== exp.size()) begin
            n_fail++; $display("FAIL %s points: got %0d required %0d", nm, pts.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < pts.size(); i++) begin
            n_chk++;
            if (pts[i] !== exp[i]) begin
                n_fail++; $display("FAIL %s point[%0d]: got %h required %h", nm, i, pts[i], exp[i]);
            end
        end
        for (int i = 0; i + 1 < stb_t.size(); i++) begin
            n_chk++;
            if (stb_t[i+1] - stb_t[i] !== dw_eff + 1) begin
                n_fail++; $display("FAIL %s hold[%0d]: got %0d required %0d", nm, i, stb_t[i+1] - stb_t[i], dw_eff + 1);
            end
        end
        if (stb_t.size() > 0 && done_t >= 0) begin
            n_chk++;
            if (done_t - stb_t[stb_t.size()-1] !== dw_eff) begin
                n_fail++; $display("FAIL %s done_lat: got %0d required %0d", nm, done_t - stb_t[stb_t.size()-1], dw_eff);
            end
        end
        n_chk++;
        if ({done_cnt, sync_cnt, 31'd0, end_busy} !== {32'd1, 32'd1, 32'd0}) begin
            n_fail++; $display("FAIL %s pulses: done=%0d sync=%0d busy_after=%0b required 1 1 0", nm, done_cnt, sync_cnt, end_busy);
        end
        n_chk++;
        if (exp.size() > 0 && bus.freq_word !== exp[exp.size()-1]) begin
            n_fail++; $display("FAIL %s hold_last: got %h required %h", nm, bus.freq_word, exp[exp.size()-1]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if ({bus.freq_word, bus.amplitude, bus.sad_freq, bus.dds_sync, bus.step_stb, bus.busy, bus.done} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs freq=%h amp=%h sad=%h busy=%b", bus.freq_word, bus.amplitude, bus.sad_freq, bus.busy);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.step_stb, bus.dds_sync, bus.done} !== 4'b0) begin
            n_fail++; $display("FAIL reset_release: got busy/stb/sync/done %b required 0000", {bus.busy, bus.step_stb, bus.dds_sync, bus.done});
        end
    endtask

    task automatic test_up_sweep();
        logic [31:0] exp[$];
`ifdef SWEEP_BIDIR_EN
        exp = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd300, 32'd200, 32'd100};
`else
        exp = '{32'd100, 32'd200, 32'd300, 32'd400};
`endif
        run_sweep(32'd100, 32'd400, 32'd100, 16'd3);
        check_sweep("up_sweep", exp, 3);
        n_chk++;
        if ({bus.amplitude, bus.sad_freq} !== {8'h5A, 32'h1234_5678}) begin
            n_fail++; $display("FAIL up_amp_sad: got %h/%h required 5a/12345678", bus.amplitude, bus.sad_freq);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] exp[$];
`ifdef SWEEP_BIDIR_EN
        exp = '{32'd100, 32'd200, 32'd300, 32'd350, 32'd250, 32'd150, 32'd100};
`else
        exp = '{32'd100, 32'd200, 32'd300, 32'd350};
`endif
        run_sweep(32'd100, 32'd350, 32'd100, 16'd2);
        check_sweep("clamp", exp, 2);
    endtask

    task automatic test_carry();
        logic [31:0] exp[$];
`ifdef SWEEP_BIDIR_EN
        exp = '{32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FF00};
`else
        exp = '{32'hFFFF_FF00, 32'hFFFF_FFFF};
`endif
        run_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 16'd1);
        check_sweep("carry", exp, 1);
    endtask

    task automatic test_single_point();
        logic [31:0] exp[$];
        exp = '{32'd700};
        run_sweep(32'd700, 32'd900, 32'd0, 16'd0);
        check_sweep("step_zero", exp, 1);
        run_sweep(32'd900, 32'd300, 32'd50, 16'd2);
        exp = '{32'd900};
        check_sweep("start_ge_stop", exp, 2);
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus.f_start = 32'd100; bus.f_stop = 32'd400; bus.f_step = 32'd100; bus.dwell = 16'd3;
        bus.start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_chk++;
                if (bus.freq_word !== 32'd200) begin
                    n_fail++; $display("FAIL abort_ignore_start: got %0d required 200", bus.freq_word);
                end
            end
            if (c == 8) begin
                n_chk++;
                if ({bus.step_stb, bus.freq_word} !== {1'b1, 32'd300}) begin
                    n_fail++; $display("FAIL abort_third_point: got stb=%b freq=%0d required 1 300", bus.step_stb, bus.freq_word);
                end
            end
            bus.start = (c == 2);
            if (c == 2) bus.f_start = 32'd5000;
            bus.abort = (c == 9);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        n_chk++;
        if ({bus.busy, bus.freq_word, bus.done} !== 34'd0) begin
            n_fail++; $display("FAIL abort_state: got busy=%b freq=%0d done=%b required 0 0 0", bus.busy, bus.freq_word, bus.done);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.done, bus.busy, bus.step_stb} !== 3'b0) begin
                n_fail++; $display("FAIL abort_quiet[%0d]: got done/busy/stb %b required 000", c, {bus.done, bus.busy, bus.step_stb});
            end
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        bus.f_start = 32'd10; bus.f_stop = 32'd40; bus.f_step = 32'd10; bus.dwell = 16'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_chk++;
            if ({bus.busy, bus.step_stb, bus.dds_sync} !== 3'b0) begin
                n_fail++; $display("FAIL start_abort[%0d]: got busy/stb/sync %b required 000", c, {bus.busy, bus.step_stb, bus.dds_sync});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus.f_start = 32'd100; bus.f_stop = 32'd400; bus.f_step = 32'd100; bus.dwell = 16'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy: got %b required 1", bus.busy);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.freq_word, bus.amplitude, bus.sad_freq, bus.dds_sync, bus.step_stb, bus.busy, bus.done} !== '0) begin
            n_fail++; $display("FAIL rst_async: got freq=%h amp=%h sad=%h busy=%b required all 0", bus.freq_word, bus.amplitude, bus.sad_freq, bus.busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++;
            if ({bus.busy, bus.step_stb, bus.dds_sync, bus.done} !== 4'b0) begin
                n_fail++; $display("FAIL rst_release[%0d]: got busy/stb/sync/done %b required 0000", c, {bus.busy, bus.step_stb, bus.dds_sync, bus.done});
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;
        bus.amp_in = '0; bus.sad_in = '0;
        test_reset();
        test_up_sweep();
        test_clamp();
        test_carry();
        test_single_point();
        test_abort();
        test_start_abort();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
